// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Packs field-level instruction requests into 32-bit words using the CPU's
//   4-bit opcode map and streams them into instruction memory at sequential
//   word addresses starting at BASE_ADDR. Used to load programs while the CPU
//   is still held in reset.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start                 begin a load session (IDLE/DONE only)
//   in_valid / in_ready   request handshake
//   in_op/rd/rs/rt/imm    instruction fields; in_last marks the final beat
//   imem_we/addr/wd       one-cycle write strobe, byte address, encoded word
//   words                 words written this session
//   busy / done / full    LOAD state, DONE state, DEPTH words written
//   err                   sticky range violation, cleared by start/reset
module instr_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_op,
  input  logic [4:0]                in_rd,
  input  logic [4:0]                in_rs,
  input  logic [4:0]                in_rt,
  input  logic [31:0]               in_imm,
  input  logic                      in_last,
  output logic                      imem_we,
  output logic [31:0]               imem_addr,
  output logic [31:0]               imem_wd,
  output logic [$clog2(DEPTH):0]    words,
  output logic                      busy,
  output logic                      done,
  output logic                      full,
  output logic                      err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;     // word offset from BASE_ADDR
  logic [AW:0]     words_q, words_d;
  logic            err_q, err_d;
  logic            full_q, full_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wd_q, wd_d;

  logic            i_type, j_type;
  logic            range_ok;
  logic [31:0]     enc;

  // Opcode classes: 0000-0101 I-type, 0110-0111 J-type, 1xxx R-type.
  always_comb begin
    j_type = (in_op[3:1] == 3'b011);
    i_type = !in_op[3] && !j_type;
    if (i_type)
      enc = {in_op, in_rt, in_rs, in_imm[17:0]};
    else if (j_type)
      enc = {in_op, in_imm[27:0]};
    else
      enc = {in_op, in_rd, in_rs, in_rt, 13'b0};
    // I-type: imm must be an 18-bit signed value (upper bits sign copies).
    // J-type: imm must fit 28 bits unsigned. R-type ignores imm.
    if (i_type)
      range_ok = (in_imm[31:17] == {15{in_imm[17]}});
    else if (j_type)
      range_ok = (in_imm[31:28] == 4'b0);
    else
      range_ok = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    words_d = words_q;
    err_d   = err_q;
    full_d  = full_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          ptr_d   = '0;
          words_d = '0;
          err_d   = 1'b0;
          full_d  = 1'b0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (range_ok) begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + {{(30-AW){1'b0}}, ptr_q, 2'b00};
            wd_d    = enc;
            ptr_d   = ptr_q + 1'b1;   // wraps modulo DEPTH words
            words_d = words_q + 1'b1;
            if (words_d == (AW+1)'(DEPTH)) begin
              full_d  = 1'b1;
              state_d = DONE;
            end
          end else begin
            err_d = 1'b1;             // beat consumed but dropped
          end
          if (in_last) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      words_q <= words_d;
      err_q   <= err_d;
      full_q  <= full_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
    end
  end

  // A write registered just before reset rises must not reach memory, so the
  // strobe is masked by reset in the cycle it would have been driven.
  assign imem_we   = we_q && !reset;
  assign imem_addr = addr_q;
  assign imem_wd   = wd_q;
  assign words     = words_q;
  assign err       = err_q;
  assign full      = full_q;
  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q == LOAD);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, in_rs, in_rt;
  logic [31:0] in_imm;
  logic        in_ready, imem_we, busy, done, full, err;
  logic [31:0] imem_addr, imem_wd;
  logic [2:0]  words;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  instr_encoder_loader #(.BASE_ADDR(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs),
    .in_rt(in_rt), .in_imm(in_imm), .in_last(in_last), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wd(imem_wd), .words(words), .busy(busy),
    .done(done), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe pops and compares the oldest expectation.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", imem_addr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("write_addr", imem_addr, e[63:32]);
        chk("write_data", imem_wd, e[31:0]);
      end
    end
  end

  // Called at a negedge: presents a beat, waits (bounded) for ready, and
  // returns at the negedge after the accepting edge with in_valid low.
  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [31:0] imm, input logic last,
                      input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    int n = 0;
    if (wr) exp_q.push_back({addr, wd});
    in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'(n), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_imm = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {imem_we, in_ready, busy, done, full, err, 23'(words)}, 32'd0);
    chk("reset_addr_wd", imem_addr | imem_wd, 32'd0);

    // ADD single beat
    pulse_start();
    chk("busy_after_start", {busy, in_ready, done}, 32'b110);
    send(4'hD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b1, 32'h0, 32'hD184_4000);
    chk("add_done_words", {done, busy, 4'(words)}, {26'd0, 1'b1, 1'b0, 4'd1});
    @(negedge clk);
    chk("add_in_ready_low", {31'd0, in_ready}, 32'd0);

    // ADDI, LW, J back-to-back
    pulse_start();
    chk("restart_words", 32'(words), 32'd0);
    send(4'h1, 5'd0, 5'd0, 5'd4, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 32'h1203_FFFF);
    send(4'h3, 5'd0, 5'd29, 5'd5, 32'd8, 1'b0, 1'b1, 32'h4, 32'h32F4_0008);
    send(4'h6, 5'd0, 5'd0, 5'd0, 32'h40, 1'b1, 1'b1, 32'h8, 32'h6000_0040);
    chk("seq_words_done", {done, 4'(words)}, {27'd0, 1'b1, 4'd3});
    @(negedge clk);

    // Range error then ADD; start in LOAD is ignored
    pulse_start();
    send(4'h1, 5'd0, 5'd0, 5'd4, 32'd131072, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("err_set", {err, 4'(words)}, {27'd0, 1'b1, 4'd0});
    pulse_start();   // ignored: still LOAD
    chk("start_in_load_ignored", {busy, err}, 32'b11);
    send(4'hD, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0, 32'hD184_4000);
    send(4'h7, 5'd0, 5'd0, 5'd0, 32'h0FFF_FFFF, 1'b1, 1'b1, 32'h4, 32'h7FFF_FFFF);
    chk("err_sticky_done", {err, done, 4'(words)}, {26'd0, 2'b11, 4'd2});
    @(negedge clk);

    // Restart from DONE clears err/words; last beat out of range ends without write
    pulse_start();
    chk("restart_clears", {err, busy, 4'(words)}, {26'd0, 2'b01, 4'd0});
    send(4'h6, 5'd0, 5'd0, 5'd0, 32'h1000_0000, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("bad_last_ends", {done, err, 4'(words)}, {26'd0, 2'b11, 4'd0});
    @(negedge clk);

    // Fill: DEPTH words with last=0
    pulse_start();
    for (int i = 0; i < DEPTH; i++)
      send(4'h8, 5'(i), 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'(4*i),
           {4'h8, 5'(i), 5'd1, 5'd2, 13'd0});
    chk("fill_status", {full, done, in_ready, 4'(words)}, {25'd0, 3'b110, 4'd4});
    in_op = 4'hF; in_valid = 1'b1; in_last = 1'b0;
    begin
      int acc = 0;
      for (int i = 0; i < 5; i++) begin
        if (in_ready === 1'b1) acc++;
        @(negedge clk);
      end
      chk("fifth_beat_refused", 32'(acc), 32'd0);
    end
    in_valid = 1'b0;

    // Reset the cycle after an accept suppresses the pending write
    pulse_start();
    in_op = 4'h9; in_rd = 5'd1; in_rs = 5'd2; in_rt = 5'd3; in_last = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("reset_kills_write", {31'd0, imem_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_mid_outputs", {imem_we, in_ready, busy, done, full, err, 23'(words)}, 32'd0);
    chk("reset_mid_addr_wd", imem_addr | imem_wd, 32'd0);
    pulse_start();
    send(4'hD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b1, 32'h0, 32'hD184_4000);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
